// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle fetch-to-decode latency with fetch-fault tagging.
// Stall holds the slot (and defers any flush); flush loads a bubble; outputs are flop-only.
module if_id_reg #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc_4add,
  input  logic [31:0]      if_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_4add,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             id_exc,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

  // Declaration initialisers give the reset image before the first clock edge.
  logic [31:0]      id_pc_q         = IM_BASE;
  logic [31:0]      id_pc_4add_q    = IM_BASE + 32'd4;
  logic [31:0]      id_instr_q      = 32'h0;
  logic             id_valid_q      = 1'b0;
  logic             id_exc_q        = 1'b0;
  state_e           state_q         = BUBBLE;
  logic             pending_flush_q = 1'b0;
  logic [CNT_W-1:0] stall_cnt_q     = '0;
  logic [CNT_W-1:0] flush_cnt_q     = '0;

  logic [31:0]      id_pc_d;
  logic [31:0]      id_pc_4add_d;
  logic [31:0]      id_instr_d;
  logic             id_valid_d;
  logic             id_exc_d;
  state_e           state_d;
  logic             pending_flush_d;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_d;

  logic fetch_fault;

  assign fetch_fault = (|if_pc[1:0]) || (if_pc < IM_BASE) || (if_pc > IM_LAST);

  always_comb begin
    id_pc_d         = id_pc_q;
    id_pc_4add_d    = id_pc_4add_q;
    id_instr_d      = id_instr_q;
    id_valid_d      = id_valid_q;
    id_exc_d        = id_exc_q;
    state_d         = state_q;
    pending_flush_d = pending_flush_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;

    if (stall) begin
      // Slot frozen; a flush seen now is remembered and applied once on release.
      state_d         = HOLD;
      pending_flush_d = pending_flush_q | flush;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (flush || pending_flush_q) begin
      id_pc_d         = if_pc;
      id_pc_4add_d    = if_pc_4add;
      id_instr_d      = 32'h0;
      id_valid_d      = 1'b0;
      id_exc_d        = 1'b0;
      state_d         = BUBBLE;
      pending_flush_d = 1'b0;
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else begin
      id_pc_d      = if_pc;
      id_pc_4add_d = if_pc_4add;
      id_instr_d   = fetch_fault ? 32'h0 : if_instr;
      id_valid_d   = 1'b1;
      id_exc_d     = fetch_fault;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc_q         <= IM_BASE;
      id_pc_4add_q    <= IM_BASE + 32'd4;
      id_instr_q      <= 32'h0;
      id_valid_q      <= 1'b0;
      id_exc_q        <= 1'b0;
      state_q         <= BUBBLE;
      pending_flush_q <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      id_pc_q         <= id_pc_d;
      id_pc_4add_q    <= id_pc_4add_d;
      id_instr_q      <= id_instr_d;
      id_valid_q      <= id_valid_d;
      id_exc_q        <= id_exc_d;
      state_q         <= state_d;
      pending_flush_q <= pending_flush_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign id_pc      = id_pc_q;
  assign id_pc_4add = id_pc_4add_q;
  assign id_instr   = id_instr_q;
  assign id_valid   = id_valid_q;
  assign id_exc     = id_exc_q;
  assign state      = state_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: default instance plus a narrow-counter, deeper-memory instance.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] if_pc = 32'h3000;
  logic [31:0] if_pc_4add = 32'h3004;
  logic [31:0] if_instr = 32'h0;

  logic [31:0] id_pc, id_pc_4add, id_instr;
  logic        id_valid, id_exc;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_pc, s_pc_4add, s_instr;
  logic        s_valid, s_exc;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_id_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_pc_4add(if_pc_4add), .if_instr(if_instr),
    .id_pc(id_pc), .id_pc_4add(id_pc_4add), .id_instr(id_instr),
    .id_valid(id_valid), .id_exc(id_exc), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_reg #(.IM_WORDS(2048), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_pc_4add(if_pc_4add), .if_instr(if_instr),
    .id_pc(s_pc), .id_pc_4add(s_pc_4add), .id_instr(s_instr),
    .id_valid(s_valid), .id_exc(s_exc), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    if_pc      = pc;
    if_pc_4add = pc + 32'd4;
    if_instr   = instr;
  endtask

  initial begin
    #1;
    chk("init_pc",    id_pc, 32'h3000);
    chk("init_pc4",   id_pc_4add, 32'h3004);
    chk("init_valid", {31'b0, id_valid}, 32'd0);
    chk("init_state", {30'b0, state}, 32'd2);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_pc",    id_pc, 32'h3000);
    chk("rst_pc4",   id_pc_4add, 32'h3004);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_exc",   {31'b0, id_exc}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd2);
    chk("rst_scnt",  {16'b0, stall_cnt}, 32'd0);
    chk("rst_fcnt",  {16'b0, flush_cnt}, 32'd0);

    // First load
    fetch(32'h3000, 32'h3C01_0001); tick();
    chk("ld_pc",    id_pc, 32'h3000);
    chk("ld_pc4",   id_pc_4add, 32'h3004);
    chk("ld_instr", id_instr, 32'h3C01_0001);
    chk("ld_valid", {31'b0, id_valid}, 32'd1);
    chk("ld_exc",   {31'b0, id_exc}, 32'd0);
    chk("ld_state", {30'b0, state}, 32'd0);

    // Stall 3 cycles while fetch side keeps changing
    fetch(32'h3004, 32'h8C22_0000); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h3100 + 32'(4 * i), 32'hAAAA_0000 + 32'(i));
      tick();
    end
    chk("hold_pc",    id_pc, 32'h3004);
    chk("hold_pc4",   id_pc_4add, 32'h3008);
    chk("hold_instr", id_instr, 32'h8C22_0000);
    chk("hold_valid", {31'b0, id_valid}, 32'd1);
    chk("hold_state", {30'b0, state}, 32'd1);
    chk("hold_scnt",  {16'b0, stall_cnt}, 32'd3);
    chk("hold_scnt_s", {28'b0, s_stall_cnt}, 32'd3);

    stall = 1'b0;
    fetch(32'h3008, 32'h0022_1820); tick();
    chk("rel_state", {30'b0, state}, 32'd0);
    chk("rel_pc",    id_pc, 32'h3008);

    // Plain flush
    flush = 1'b1;
    fetch(32'h3010, 32'hDEAD_BEEF); tick();
    flush = 1'b0;
    chk("fl_valid", {31'b0, id_valid}, 32'd0);
    chk("fl_instr", id_instr, 32'h0);
    chk("fl_pc",    id_pc, 32'h3010);
    chk("fl_pc4",   id_pc_4add, 32'h3014);
    chk("fl_fcnt",  {16'b0, flush_cnt}, 32'd1);
    chk("fl_state", {30'b0, state}, 32'd2);

    fetch(32'h3014, 32'h1234_5678); tick();
    chk("bub_run_state", {30'b0, state}, 32'd0);
    chk("bub_run_valid", {31'b0, id_valid}, 32'd1);

    // Stall + flush together for 2 cycles: held, flush deferred and counted once
    stall = 1'b1; flush = 1'b1;
    fetch(32'h3018, 32'h9999_9999);
    tick(); tick();
    chk("sf_pc",    id_pc, 32'h3014);
    chk("sf_valid", {31'b0, id_valid}, 32'd1);
    chk("sf_state", {30'b0, state}, 32'd1);
    chk("sf_fcnt",  {16'b0, flush_cnt}, 32'd1);
    stall = 1'b0; flush = 1'b0;
    fetch(32'h301C, 32'h1111_1111); tick();
    chk("pf_valid", {31'b0, id_valid}, 32'd0);
    chk("pf_instr", id_instr, 32'h0);
    chk("pf_pc",    id_pc, 32'h301C);
    chk("pf_fcnt",  {16'b0, flush_cnt}, 32'd2);
    chk("pf_state", {30'b0, state}, 32'd2);
    fetch(32'h3020, 32'h2222_2222); tick();
    chk("pf_clr_valid", {31'b0, id_valid}, 32'd1);
    chk("pf_clr_fcnt",  {16'b0, flush_cnt}, 32'd2);

    // Fetch faults and range boundaries
    fetch(32'h3002, 32'h3333_3333); tick();
    chk("mis_exc",   {31'b0, id_exc}, 32'd1);
    chk("mis_instr", id_instr, 32'h0);
    chk("mis_valid", {31'b0, id_valid}, 32'd1);
    chk("mis_pc",    id_pc, 32'h3002);
    fetch(32'h5000, 32'h4444_4444); tick();
    chk("oor_exc",   {31'b0, id_exc}, 32'd1);
    chk("oor_instr", id_instr, 32'h0);
    chk("oor_exc_s", {31'b0, s_exc}, 32'd1);
    fetch(32'h3FFC, 32'h5555_5555); tick();
    chk("top_exc",   {31'b0, id_exc}, 32'd0);
    chk("top_instr", id_instr, 32'h5555_5555);
    fetch(32'h4000, 32'h6666_6666); tick();
    chk("past_exc",  {31'b0, id_exc}, 32'd1);
    fetch(32'h2FFC, 32'h7777_7777); tick();
    chk("low_exc",   {31'b0, id_exc}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl_clr_exc", {31'b0, id_exc}, 32'd0);
    fetch(32'h4FFC, 32'h8888_8888); tick();
    chk("top_exc_s",   {31'b0, s_exc}, 32'd0);
    chk("top_instr_s", s_instr, 32'h8888_8888);
    chk("big_exc",     {31'b0, id_exc}, 32'd1);

    // Long stall: narrow counter saturates; pulse a flush to leave one pending
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      flush = (i == 7);
      tick();
    end
    flush = 1'b0;
    chk("sat_scnt_s", {28'b0, s_stall_cnt}, 32'd15);
    chk("sat_scnt",   {16'b0, stall_cnt}, 32'd25);

    // Reset mid-stall with a pending flush: reset wins, no bubble afterwards
    reset = 1'b1; flush = 1'b1; tick();
    reset = 1'b0; flush = 1'b0;
    chk("rst2_state", {30'b0, state}, 32'd2);
    chk("rst2_pc",    id_pc, 32'h3000);
    chk("rst2_scnt",  {16'b0, stall_cnt}, 32'd0);
    chk("rst2_fcnt",  {16'b0, flush_cnt}, 32'd0);
    chk("rst2_valid", {31'b0, id_valid}, 32'd0);
    stall = 1'b0;
    fetch(32'h3000, 32'h2402_0005); tick();
    chk("rel2_valid", {31'b0, id_valid}, 32'd1);
    chk("rel2_instr", id_instr, 32'h2402_0005);
    chk("rel2_state", {30'b0, state}, 32'd0);
    chk("rel2_fcnt",  {16'b0, flush_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
